// File: rtl/hero_write_assembler.sv
// hero_write_assembler
// ---------------------------------------------------------------------------
// Store-and-forward assembler for the hero write bus. Beats arriving on the
// hero bus (which has no backpressure) are buffered in a small flop array and
// only released downstream, over a valid/ready stream, once the whole
// transaction has been terminated by a DONE beat. Transactions that are
// malformed (illegal cycle type), too long, or that would overflow the
// buffer are discarded whole and reported on the err_* outputs.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   in_cycle_type  hero cycle type: 0=IDLE, 1=VALID, 2=DONE, 3=illegal
//   in_wdat        hero write data
//   in_clk_en      beat qualifier; the beat is ignored when low
//   out_valid      a committed beat is available downstream
//   out_ready      downstream accepts the current beat
//   out_wdat       beat data
//   out_last       final beat of the transaction
//   out_beat_idx   beat index within the transaction, starting at 0
//   err_drop       one-cycle pulse: a transaction was discarded
//   err_code       cause of the latest drop: 1=too long, 2=overflow, 3=illegal
//   err_sticky     set on any drop, cleared by err_clr (a drop wins)
//   err_clr        clears err_sticky
// ---------------------------------------------------------------------------
module hero_write_assembler #(
   parameter int HERO_WIDTH = 36,
   parameter int DEPTH      = 16,
   parameter int MAX_BEATS  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   in_cycle_type,
   input  logic [HERO_WIDTH-1:0]        in_wdat,
   input  logic                         in_clk_en,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [HERO_WIDTH-1:0]        out_wdat,
   output logic                         out_last,
   output logic [$clog2(MAX_BEATS)-1:0] out_beat_idx,
   output logic                         err_drop,
   output logic [1:0]                   err_code,
   output logic                         err_sticky,
   input  logic                         err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int IW = $clog2(MAX_BEATS);
   localparam int LW = $clog2(MAX_BEATS + 1);

   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);
   localparam logic [LW:0]   LEN_ONE   = (LW+1)'(1);
   localparam logic [LW:0]   LEN_LIMIT = (LW+1)'(MAX_BEATS);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);

   localparam logic [1:0] CT_IDLE    = 2'd0;
   localparam logic [1:0] CT_VALID   = 2'd1;
   localparam logic [1:0] CT_DONE    = 2'd2;
   localparam logic [1:0] CT_ILLEGAL = 2'd3;

   localparam logic [1:0] ERR_TOO_LONG = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;
   localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_DROP
   } state_t;

   state_t                state;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         commit_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [LW-1:0]         len;

   logic [HERO_WIDTH:0]   mem [DEPTH];
   logic [HERO_WIDTH:0]   rd_entry;

   logic                  beat_acc;
   logic                  is_valid;
   logic                  is_done;
   logic                  is_illegal;
   logic                  checking;
   logic                  too_long;
   logic                  buf_full;
   logic                  drop_now;
   logic                  write_now;
   logic                  commit_now;
   logic                  pop;
   logic [1:0]            drop_code;
   logic [PW-1:0]         occupancy;
   logic [LW:0]           len_inc;
   logic [PW-1:0]         rd_ptr_nxt;
   logic [PW-1:0]         commit_ptr_nxt;

   // The head entry is read straight out of the array. Because a push is
   // refused whenever the buffer is full, the slot under rd_ptr can never be
   // overwritten while it is being presented, so the outputs hold steady
   // during a stall without needing a separate output register.
   assign rd_entry = mem[rd_ptr[AW-1:0]];
   assign out_wdat = rd_entry[HERO_WIDTH-1:0];
   assign out_last = rd_entry[HERO_WIDTH];

   // Decode the incoming beat and decide what happens to it this cycle.
   // Occupancy counts uncommitted beats too and uses the pointer values from
   // before any pop, so a pop in the same cycle never makes room for a push.
   // The drop causes are prioritised illegal > too long > overflow; while in
   // DROP no checks are made, the beat simply gets swallowed.
   always_comb begin
      beat_acc       = in_clk_en && (in_cycle_type != CT_IDLE);
      is_valid       = in_cycle_type == CT_VALID;
      is_done        = in_cycle_type == CT_DONE;
      is_illegal     = in_cycle_type == CT_ILLEGAL;
      checking       = beat_acc && (state != ST_DROP);
      occupancy      = wr_ptr - rd_ptr;
      buf_full       = occupancy == PTR_DEPTH;
      len_inc        = {1'b0, len} + LEN_ONE;
      too_long       = len_inc > LEN_LIMIT;
      drop_now       = checking && (is_illegal || too_long || buf_full);
      write_now      = checking && !drop_now;
      commit_now     = write_now && is_done;
      pop            = out_valid && out_ready;
      rd_ptr_nxt     = pop ? rd_ptr + PTR_ONE : rd_ptr;
      commit_ptr_nxt = commit_now ? wr_ptr + PTR_ONE : commit_ptr;
      drop_code      = ERR_OVERFLOW;
      if (is_illegal) begin
         drop_code = ERR_ILLEGAL;
      end else if (too_long) begin
         drop_code = ERR_TOO_LONG;
      end
   end

   // Input FSM and write side pointers. A drop rewinds wr_ptr to the last
   // commit point so the partial transaction vanishes; a VALID drop then
   // waits in DROP for the terminating DONE/illegal beat, while a DONE or
   // illegal drop is already the end of the transaction. A DONE from IDLE is
   // a complete single-beat transaction and commits immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         len        <= '0;
      end else begin
         commit_ptr <= commit_ptr_nxt;
         if (drop_now) begin
            wr_ptr <= commit_ptr;
            len    <= '0;
            state  <= is_valid ? ST_DROP : ST_IDLE;
         end else if (write_now) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (is_done) begin
               len   <= '0;
               state <= ST_IDLE;
            end else begin
               len   <= len_inc[LW-1:0];
               state <= ST_COLLECT;
            end
         end else if ((state == ST_DROP) && beat_acc && (is_done || is_illegal)) begin
            state <= ST_IDLE;
         end
      end
   end

   // Beat storage. The extra top bit marks the DONE beat so the read side
   // knows where each transaction ends without any length bookkeeping.
   always_ff @(posedge clk) begin
      if (write_now) begin
         mem[wr_ptr[AW-1:0]] <= {is_done, in_wdat};
      end
   end

   // Read side. out_valid is registered but computed from the next-state
   // pointers, so a commit shows up the cycle right after DONE is sampled and
   // a pop of the last committed beat drops valid without a stale extra
   // cycle. Commit and pop in the same cycle both take effect, which lets
   // back-to-back transactions stream without bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr       <= '0;
         out_valid    <= 1'b0;
         out_beat_idx <= '0;
      end else begin
         rd_ptr    <= rd_ptr_nxt;
         out_valid <= rd_ptr_nxt != commit_ptr_nxt;
         if (pop) begin
            out_beat_idx <= out_last ? '0 : out_beat_idx + IDX_ONE;
         end
      end
   end

   // Error reporting. err_drop pulses for one cycle after the offending beat,
   // err_code remembers the latest cause until the next drop, and err_sticky
   // latches until software clears it; a drop in the clearing cycle wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_drop   <= 1'b0;
         err_code   <= '0;
         err_sticky <= 1'b0;
      end else begin
         err_drop <= drop_now;
         if (drop_now) begin
            err_code   <= drop_code;
            err_sticky <= 1'b1;
         end else if (err_clr) begin
            err_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hero_write_assembler.sv
// tb_hero_write_assembler
// ---------------------------------------------------------------------------
// Self-checking bench for hero_write_assembler. A transaction-level model
// (queues of committed beats and of the transaction being collected) predicts
// every output, a compare process checks the DUT against it on each falling
// edge, and the directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_hero_write_assembler;

   localparam int HW        = 36;
   localparam int DEPTH     = 16;
   localparam int MAX_BEATS = 8;
   localparam int IW        = $clog2(MAX_BEATS);

   localparam logic [1:0] T_IDLE    = 2'd0;
   localparam logic [1:0] T_VALID   = 2'd1;
   localparam logic [1:0] T_DONE    = 2'd2;
   localparam logic [1:0] T_ILLEGAL = 2'd3;

   logic           clk = 1'b0;
   logic           rst;
   logic [1:0]     in_cycle_type;
   logic [HW-1:0]  in_wdat;
   logic           in_clk_en;
   logic           out_valid;
   logic           out_ready;
   logic [HW-1:0]  out_wdat;
   logic           out_last;
   logic [IW-1:0]  out_beat_idx;
   logic           err_drop;
   logic [1:0]     err_code;
   logic           err_sticky;
   logic           err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   hero_write_assembler #(
      .HERO_WIDTH (HW),
      .DEPTH      (DEPTH),
      .MAX_BEATS  (MAX_BEATS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_cycle_type (in_cycle_type),
      .in_wdat       (in_wdat),
      .in_clk_en     (in_clk_en),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_wdat      (out_wdat),
      .out_last      (out_last),
      .out_beat_idx  (out_beat_idx),
      .err_drop      (err_drop),
      .err_code      (err_code),
      .err_sticky    (err_sticky),
      .err_clr       (err_clr)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Transaction-level reference: beats waiting downstream, beats of the
   // transaction still being collected, and whether we are discarding.
   typedef struct {
      logic [HW-1:0] data;
      logic          last;
      int            idx;
   } beat_t;

   typedef enum int { M_IDLE, M_COLLECT, M_DROP } mode_t;

   beat_t         m_out[$];
   logic [HW-1:0] m_part[$];
   mode_t         m_mode   = M_IDLE;
   bit            m_drop   = 1'b0;
   logic [1:0]    m_code   = 2'd0;
   bit            m_sticky = 1'b0;
   int            m_occ;
   bit            m_pop;
   bit            m_dropped;
   logic [1:0]    m_new_code;
   beat_t         m_b;

   // Comparison helper shared by the directed checks and the compare process.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the reference model by one clock: the downstream pop is decided
   // from what was presented before the edge, the space check counts every
   // buffered beat (committed or not) before that pop, and a transaction
   // moves to the downstream queue in one go when its DONE arrives.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_out.delete();
         m_part.delete();
         m_mode   = M_IDLE;
         m_drop   = 1'b0;
         m_code   = 2'd0;
         m_sticky = 1'b0;
      end else begin
         m_occ      = m_out.size() + m_part.size();
         m_pop      = (m_out.size() > 0) && out_ready;
         m_dropped  = 1'b0;
         m_new_code = 2'd0;
         if (m_pop) begin
            m_b = m_out.pop_front();
         end
         if (in_clk_en && (in_cycle_type != T_IDLE)) begin
            if (m_mode == M_DROP) begin
               if (in_cycle_type == T_DONE || in_cycle_type == T_ILLEGAL) begin
                  m_mode = M_IDLE;
               end
            end else begin
               if (in_cycle_type == T_ILLEGAL) begin
                  m_dropped  = 1'b1;
                  m_new_code = 2'd3;
               end else if (m_part.size() + 1 > MAX_BEATS) begin
                  m_dropped  = 1'b1;
                  m_new_code = 2'd1;
               end else if (m_occ == DEPTH) begin
                  m_dropped  = 1'b1;
                  m_new_code = 2'd2;
               end
               if (m_dropped) begin
                  m_part.delete();
                  m_mode = (in_cycle_type == T_VALID) ? M_DROP : M_IDLE;
               end else if (in_cycle_type == T_VALID) begin
                  m_part.push_back(in_wdat);
                  m_mode = M_COLLECT;
               end else begin
                  for (int i = 0; i < m_part.size(); i++) begin
                     m_b.data = m_part[i];
                     m_b.last = 1'b0;
                     m_b.idx  = i;
                     m_out.push_back(m_b);
                  end
                  m_b.data = in_wdat;
                  m_b.last = 1'b1;
                  m_b.idx  = m_part.size();
                  m_out.push_back(m_b);
                  m_part.delete();
                  m_mode = M_IDLE;
               end
            end
         end
         m_drop = m_dropped;
         if (m_dropped) begin
            m_code   = m_new_code;
            m_sticky = 1'b1;
         end else if (err_clr) begin
            m_sticky = 1'b0;
         end
      end
   end

   // Every falling edge, compare the DUT against the model (or against the
   // reset values while reset is held).
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
         checkOutput("rst_err_drop", 64'(err_drop), 64'(0));
         checkOutput("rst_err_code", 64'(err_code), 64'(0));
         checkOutput("rst_err_sticky", 64'(err_sticky), 64'(0));
      end else begin
         checkOutput("out_valid", 64'(out_valid), 64'(m_out.size() != 0));
         if (m_out.size() != 0) begin
            checkOutput("out_wdat", 64'(out_wdat), 64'(m_out[0].data));
            checkOutput("out_last", 64'(out_last), 64'(m_out[0].last));
            checkOutput("out_beat_idx", 64'(out_beat_idx), 64'(m_out[0].idx));
         end
         checkOutput("err_drop", 64'(err_drop), 64'(m_drop));
         checkOutput("err_code", 64'(err_code), 64'(m_code));
         checkOutput("err_sticky", 64'(err_sticky), 64'(m_sticky));
      end
   end

   // Move to just after the next rising edge, where inputs are driven and the
   // directed checks look at freshly registered outputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one accepted beat for a single cycle, then return the bus to idle.
   task automatic applyStimulus(input logic [1:0] ctype, input logic [HW-1:0] data);
      in_cycle_type = ctype;
      in_wdat       = data;
      in_clk_en     = 1'b1;
      tick();
      in_cycle_type = T_IDLE;
      in_clk_en     = 1'b0;
   endtask

   // Safety net so the run always ends even if something wedges.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by a randomized soak.
   initial begin
      int r;
      int ready_pct;
      int done_pct;

      rst           = 1'b1;
      in_cycle_type = T_IDLE;
      in_wdat       = '0;
      in_clk_en     = 1'b0;
      out_ready     = 1'b0;
      err_clr       = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      checkOutput("reset_valid", 64'(out_valid), 64'(0));
      checkOutput("reset_sticky", 64'(err_sticky), 64'(0));
      checkOutput("reset_code", 64'(err_code), 64'(0));

      $display("[TB] single-beat DONE");
      out_ready = 1'b1;
      applyStimulus(T_DONE, 36'h123456789);
      checkOutput("single_valid", 64'(out_valid), 64'(1));
      checkOutput("single_last", 64'(out_last), 64'(1));
      checkOutput("single_idx", 64'(out_beat_idx), 64'(0));
      checkOutput("single_wdat", 64'(out_wdat), 64'h123456789);
      tick();
      checkOutput("single_drained", 64'(out_valid), 64'(0));

      $display("[TB] four beats with downstream stall");
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(T_VALID, HW'(i));
      applyStimulus(T_DONE, HW'(3));
      for (int c = 0; c < 5; c++) begin
         checkOutput("stall_valid", 64'(out_valid), 64'(1));
         checkOutput("stall_wdat", 64'(out_wdat), 64'(0));
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("four_wdat", 64'(out_wdat), 64'(i));
         checkOutput("four_idx", 64'(out_beat_idx), 64'(i));
         checkOutput("four_last", 64'(out_last), 64'(i == 3));
         tick();
      end
      checkOutput("four_drained", 64'(out_valid), 64'(0));
      checkOutput("four_no_err", 64'(err_sticky), 64'(0));

      $display("[TB] too-long transaction");
      for (int i = 0; i < 9; i++) applyStimulus(T_VALID, HW'(8'h50 + i));
      checkOutput("long_drop", 64'(err_drop), 64'(1));
      checkOutput("long_code", 64'(err_code), 64'(1));
      checkOutput("long_sticky", 64'(err_sticky), 64'(1));
      checkOutput("long_no_out", 64'(out_valid), 64'(0));
      applyStimulus(T_VALID, HW'(8'h60));
      checkOutput("long_pulse_end", 64'(err_drop), 64'(0));
      applyStimulus(T_DONE, HW'(8'h61));
      checkOutput("long_still_empty", 64'(out_valid), 64'(0));
      applyStimulus(T_VALID, HW'(8'h0A));
      applyStimulus(T_DONE, HW'(8'h0B));
      checkOutput("after_long_wdat0", 64'(out_wdat), 64'h0A);
      checkOutput("after_long_idx0", 64'(out_beat_idx), 64'(0));
      tick();
      checkOutput("after_long_wdat1", 64'(out_wdat), 64'h0B);
      checkOutput("after_long_last1", 64'(out_last), 64'(1));
      tick();
      checkOutput("after_long_empty", 64'(out_valid), 64'(0));

      $display("[TB] buffer overflow");
      out_ready = 1'b0;
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i < 7; i++) applyStimulus(T_VALID, HW'(12'h100 * (t + 1) + i));
         applyStimulus(T_DONE, HW'(12'h100 * (t + 1) + 7));
      end
      checkOutput("model_full", 64'(m_out.size()), 64'(16));
      applyStimulus(T_VALID, HW'(12'h999));
      checkOutput("ovf_drop", 64'(err_drop), 64'(1));
      checkOutput("ovf_code", 64'(err_code), 64'(2));
      applyStimulus(T_VALID, HW'(12'h99A));
      applyStimulus(T_DONE, HW'(12'h99B));
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("ovf_cleared", 64'(err_sticky), 64'(0));
      out_ready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i < 8; i++) begin
            checkOutput("ovf_drain_wdat", 64'(out_wdat), 64'(12'h100 * (t + 1) + i));
            checkOutput("ovf_drain_idx", 64'(out_beat_idx), 64'(i));
            checkOutput("ovf_drain_last", 64'(out_last), 64'(i == 7));
            tick();
         end
      end
      checkOutput("ovf_drained", 64'(out_valid), 64'(0));

      $display("[TB] illegal type mid-transaction");
      applyStimulus(T_VALID, HW'(8'h31));
      applyStimulus(T_VALID, HW'(8'h32));
      applyStimulus(T_ILLEGAL, HW'(8'h33));
      checkOutput("ill_drop", 64'(err_drop), 64'(1));
      checkOutput("ill_code", 64'(err_code), 64'(3));
      checkOutput("ill_no_out", 64'(out_valid), 64'(0));
      applyStimulus(T_VALID, HW'(8'h41));
      applyStimulus(T_DONE, HW'(8'h42));
      checkOutput("ill_next_wdat0", 64'(out_wdat), 64'h41);
      tick();
      checkOutput("ill_next_wdat1", 64'(out_wdat), 64'h42);
      checkOutput("ill_next_idx1", 64'(out_beat_idx), 64'(1));
      tick();

      $display("[TB] reset mid-drain");
      out_ready = 1'b0;
      for (int i = 1; i < 4; i++) applyStimulus(T_VALID, HW'(8'h60 + i));
      applyStimulus(T_DONE, HW'(8'h64));
      out_ready = 1'b1;
      tick();
      checkOutput("rd_mid_wdat", 64'(out_wdat), 64'h62);
      rst = 1'b1;
      #1;
      checkOutput("rd_async_valid", 64'(out_valid), 64'(0));
      tick();
      tick();
      rst = 1'b0;
      checkOutput("rd_after_valid", 64'(out_valid), 64'(0));
      checkOutput("rd_after_sticky", 64'(err_sticky), 64'(0));
      checkOutput("rd_after_code", 64'(err_code), 64'(0));
      applyStimulus(T_DONE, HW'(8'h77));
      checkOutput("rd_new_valid", 64'(out_valid), 64'(1));
      checkOutput("rd_new_wdat", 64'(out_wdat), 64'h77);
      tick();

      $display("[TB] randomized soak");
      for (int blk = 0; blk < 10; blk++) begin
         ready_pct = (blk % 3 == 0) ? 20 : 85;
         done_pct  = (blk % 2 == 0) ? 30 : 4;
         for (int c = 0; c < 300; c++) begin
            r = $urandom_range(0, 99);
            if (r < 20)                 in_cycle_type = T_IDLE;
            else if (r < 20 + done_pct) in_cycle_type = T_DONE;
            else if (r < 96)            in_cycle_type = T_VALID;
            else                        in_cycle_type = T_ILLEGAL;
            in_wdat   = HW'({$urandom, $urandom});
            in_clk_en = $urandom_range(0, 99) < 85;
            out_ready = $urandom_range(0, 99) < ready_pct;
            err_clr   = $urandom_range(0, 99) < 5;
            tick();
         end
      end
      in_cycle_type = T_IDLE;
      in_clk_en     = 1'b0;
      err_clr       = 1'b0;
      out_ready     = 1'b1;
      repeat (40) tick();
      checkOutput("final_empty", 64'(out_valid), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
